// File: rtl/cr_huf_comp_sq_rd_if.sv
// Symbol-queue read bus and downstream entry stream for cr_huf_comp_sq_rd.
//   sq_*  : queue flags and returning entry fields (sq_rd is the pop request)
//   out_* : valid/ready stream of entries towards the Huffman encoder
// Modports: slave  = the read engine (drives sq_rd and out_*)
//           master = the surrounding queue and downstream consumer
interface cr_huf_comp_sq_rd_if;
   logic        sq_empty;
   logic        sq_aempty;
   logic [63:0] sq_data;
   logic [3:0]  sq_seq_id;
   logic        sq_eob;
   logic        sq_tlast;
   logic [2:0]  sq_byte_vld;
   logic        sq_sot;
   logic        sq_eot;
   logic        sq_rd;

   logic        out_vld;
   logic        out_rdy;
   logic [63:0] out_data;
   logic [3:0]  out_seq_id;
   logic        out_eob;
   logic        out_tlast;
   logic [2:0]  out_byte_vld;
   logic        out_sot;
   logic        out_eot;

   modport slave (
      input  sq_empty, sq_aempty, sq_data, sq_seq_id, sq_eob, sq_tlast,
             sq_byte_vld, sq_sot, sq_eot, out_rdy,
      output sq_rd, out_vld, out_data, out_seq_id, out_eob, out_tlast,
             out_byte_vld, out_sot, out_eot
   );

   modport master (
      output sq_empty, sq_aempty, sq_data, sq_seq_id, sq_eob, sq_tlast,
             sq_byte_vld, sq_sot, sq_eot, out_rdy,
      input  sq_rd, out_vld, out_data, out_seq_id, out_eob, out_tlast,
             out_byte_vld, out_sot, out_eot
   );
endinterface

// File: rtl/cr_huf_comp_sq_rd.sv
// Read-side engine of the Huffman compressor symbol queue.
// Pops the queue under a credit limit, captures returning entries into a
// small skid FIFO, streams them out on valid/ready and tracks sot/eot framing.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : symbol-queue read side and output stream (slave modport)
//   frame_bytes  : saturating byte count of accepted entries in current frame
//   frame_done   : one-cycle pulse when an eot entry is accepted
//   err_framing  : sticky framing-violation flag
// Parameters: RD_LATENCY (1..3), SKID_DEPTH (>= RD_LATENCY+1), CNT_W.
module cr_huf_comp_sq_rd #(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned SKID_DEPTH = 4,
   parameter int unsigned CNT_W      = 24
) (
   input  logic               clk,
   input  logic               rst,
   cr_huf_comp_sq_rd_if.slave bus,
   output logic [CNT_W-1:0]   frame_bytes,
   output logic               frame_done,
   output logic               err_framing
);

   localparam int unsigned PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int unsigned SCNT_W = $clog2(SKID_DEPTH + 1);
   localparam int unsigned CRD_W  = $clog2(RD_LATENCY + SKID_DEPTH + 2);

   // 75-bit queue entry as stored in the skid FIFO
   typedef struct packed {
      logic        eot;
      logic        sot;
      logic [2:0]  byte_vld;
      logic        tlast;
      logic        eob;
      logic [3:0]  seq_id;
      logic [63:0] data;
   } entry_t;

   typedef enum logic {
      ST_IDLE,
      ST_IN_FRAME
   } state_t;

   logic [RD_LATENCY-1:0] vld_pipe;
   logic                  sq_rd_prev;
   logic [CRD_W-1:0]      inflight;
   logic                  credit_ok;
   logic                  sq_rd_int;
   logic                  land;
   logic                  pop;
   entry_t                land_entry;
   entry_t                head;
   entry_t                mem [SKID_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [SCNT_W-1:0]     skid_cnt;
   state_t                state;
   logic [3:0]            nbytes;
   logic [CNT_W:0]        acc_sum;
   logic [CNT_W-1:0]      acc_sat;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Pops issued but not yet landed
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
         inflight = inflight + CRD_W'(vld_pipe[i]);
      end
   end

   // Every popped entry must find a skid slot when it lands
   assign credit_ok = (inflight + CRD_W'(skid_cnt) + CRD_W'(1)) <= CRD_W'(SKID_DEPTH);

   // Flags lag a pop by one cycle: aempty right after a pop means the
   // last entry is already on its way, so do not pop again
   assign sq_rd_int = !rst && !bus.sq_empty && !(bus.sq_aempty && sq_rd_prev) && credit_ok;
   assign bus.sq_rd = sq_rd_int;

   assign land = vld_pipe[RD_LATENCY-1];

   always_comb begin
      land_entry          = '0;
      land_entry.eot      = bus.sq_eot;
      land_entry.sot      = bus.sq_sot;
      land_entry.byte_vld = bus.sq_byte_vld;
      land_entry.tlast    = bus.sq_tlast;
      land_entry.eob      = bus.sq_eob;
      land_entry.seq_id   = bus.sq_seq_id;
      land_entry.data     = bus.sq_data;
   end

   assign head = mem[rd_ptr];
   assign pop  = bus.out_vld && bus.out_rdy;

   assign bus.out_vld      = (skid_cnt != '0);
   assign bus.out_data     = head.data;
   assign bus.out_seq_id   = head.seq_id;
   assign bus.out_eob      = head.eob;
   assign bus.out_tlast    = head.tlast;
   assign bus.out_byte_vld = head.byte_vld;
   assign bus.out_sot      = head.sot;
   assign bus.out_eot      = head.eot;

   // Read tag pipe and skid FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe   <= '0;
         sq_rd_prev <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         skid_cnt   <= '0;
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         vld_pipe   <= (vld_pipe << 1) | RD_LATENCY'(sq_rd_int);
         sq_rd_prev <= sq_rd_int;
         if (land) begin
            mem[wr_ptr] <= land_entry;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({land, pop})
            2'b10:   skid_cnt <= skid_cnt + SCNT_W'(1);
            2'b01:   skid_cnt <= skid_cnt - SCNT_W'(1);
            default: skid_cnt <= skid_cnt;
         endcase
         if (land && !pop) begin
            assert (skid_cnt != SCNT_W'(SKID_DEPTH))
               else $error("cr_huf_comp_sq_rd: skid buffer overflow");
         end
      end
   end

   // Byte count of the accepted head entry; byte_vld of 0 means a full word
   assign nbytes  = (head.byte_vld == 3'd0) ? 4'd8 : {1'b0, head.byte_vld};
   assign acc_sum = {1'b0, frame_bytes} + (CNT_W+1)'(nbytes);
   assign acc_sat = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];

   // Framing tracker, advanced only by accepted entries
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         frame_bytes <= '0;
         frame_done  <= 1'b0;
         err_framing <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (pop) begin
            case (state)
               ST_IDLE: begin
                  if (head.sot) begin
                     frame_bytes <= CNT_W'(nbytes);
                     if (head.eot) begin
                        frame_done <= 1'b1;
                     end else begin
                        state <= ST_IN_FRAME;
                     end
                  end else begin
                     err_framing <= 1'b1;
                  end
               end
               ST_IN_FRAME: begin
                  // A nested sot is an error but still starts a fresh count
                  if (head.sot) begin
                     err_framing <= 1'b1;
                     frame_bytes <= CNT_W'(nbytes);
                  end else begin
                     frame_bytes <= acc_sat;
                  end
                  if (head.eot) begin
                     frame_done <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cr_huf_comp_sq_rd.sv
// Bench for cr_huf_comp_sq_rd: a queue model with lagging flags and fixed
// read latency feeds the DUT; a scoreboard and a framing model check the stream.
module tb_cr_huf_comp_sq_rd;

   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int          SAT    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        eot;
      logic        sot;
      logic [2:0]  bv;
      logic        tlast;
      logic        eob;
      logic [3:0]  seq;
      logic [63:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cr_huf_comp_sq_rd_if bus ();
   logic [CNT_W-1:0] frame_bytes;
   logic             frame_done;
   logic             err_framing;

   cr_huf_comp_sq_rd #(
      .RD_LATENCY (RD_LAT),
      .SKID_DEPTH (DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .frame_bytes (frame_bytes),
      .frame_done  (frame_done),
      .err_framing (err_framing)
   );

   int errors = 0;
   int checks = 0;

   // upstream queue model
   ent_t q[$];
   int   flag_cnt = 0;
   ent_t ret_e [RD_LAT];
   bit   ret_v [RD_LAT];

   // scoreboard and framing model
   ent_t exp_q[$];
   bit   m_in_frame = 0;
   int   m_bytes = 0;
   bit   m_done = 0;
   bit   m_err = 0;

   int   cyc = 0;
   int   mode = 0;
   bit   prev_stall = 0;
   bit   prev_xfer = 0;
   ent_t prev_out;
   int   pops, xfers, first_rd, first_vld, first_xfer, last_xfer, done_cnt, vld_cnt;
   int   fb_log[$];
   int   done_log[$];
   int   err_log[$];

   bit               s_rd, s_vld, s_done, s_err;
   ent_t             s_out;
   logic [CNT_W-1:0] s_fb;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   function automatic ent_t mk(input bit sot, input bit eot, input int bv);
      ent_t e;
      e.data  = {$urandom(), $urandom()};
      e.seq   = 4'($urandom_range(0, 15));
      e.eob   = 1'($urandom_range(0, 1));
      e.tlast = 1'($urandom_range(0, 1));
      e.bv    = (bv < 0) ? 3'($urandom_range(0, 7)) : 3'(bv);
      e.sot   = sot;
      e.eot   = eot;
      return e;
   endfunction

   task automatic drive_inputs();
      ent_t r;
      bus.sq_empty  = (flag_cnt == 0);
      bus.sq_aempty = (flag_cnt == 1);
      r = ret_v[RD_LAT-1] ? ret_e[RD_LAT-1] : mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      bus.sq_data     = r.data;
      bus.sq_seq_id   = r.seq;
      bus.sq_eob      = r.eob;
      bus.sq_tlast    = r.tlast;
      bus.sq_byte_vld = r.bv;
      bus.sq_sot      = r.sot;
      bus.sq_eot      = r.eot;
      case (mode)
         0:       bus.out_rdy = 1'b1;
         1:       bus.out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         2:       bus.out_rdy = 1'b0;
         default: bus.out_rdy = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Apply one accepted entry to the framing rules
   task automatic frame_accept(input ent_t e);
      int nb;
      nb = (e.bv == 3'd0) ? 8 : int'(e.bv);
      if (e.sot) begin
         if (m_in_frame) m_err = 1;
         m_bytes    = nb;
         m_in_frame = !e.eot;
         if (e.eot) m_done = 1;
      end else if (!m_in_frame) begin
         m_err = 1;
      end else begin
         m_bytes = (m_bytes + nb > SAT) ? SAT : m_bytes + nb;
         if (e.eot) begin
            m_done     = 1;
            m_in_frame = 0;
         end
      end
   endtask

   task automatic reset_stats();
      pops = 0; xfers = 0; first_rd = -1; first_vld = -1;
      first_xfer = -1; last_xfer = -1; done_cnt = 0; vld_cnt = 0;
      fb_log.delete(); done_log.delete(); err_log.delete();
   endtask

   task automatic preload(input ent_t e);
      q.push_back(e);
      flag_cnt = q.size();
      drive_inputs();
   endtask

   // One clock: sample mid-cycle, check, advance models, drive next inputs
   task automatic cycle();
      ent_t o, e, pe;
      bit   rd, vld, xfer, popped;
      int   flag_next;
      @(negedge clk);
      rd  = bus.sq_rd;
      vld = bus.out_vld;
      o   = {bus.out_eot, bus.out_sot, bus.out_byte_vld, bus.out_tlast,
             bus.out_eob, bus.out_seq_id, bus.out_data};
      xfer = vld && bus.out_rdy;
      s_rd = rd; s_vld = vld; s_out = o; s_fb = frame_bytes;
      s_done = frame_done; s_err = err_framing;

      chk("pop_when_empty", 80'(rd && (q.size() == 0)), 80'(0));
      chk("frame_bytes", 80'(frame_bytes), 80'(m_bytes));
      chk("frame_done", 80'(frame_done), 80'(m_done));
      chk("err_framing", 80'(err_framing), 80'(m_err));
      if (prev_stall) begin
         chk("stall_vld", 80'(vld), 80'(1));
         chk("stall_hold", 80'(o), 80'(prev_out));
      end
      if (prev_xfer) begin
         fb_log.push_back(int'(frame_bytes));
         done_log.push_back(int'(frame_done));
         err_log.push_back(int'(err_framing));
      end
      if (frame_done) done_cnt++;
      if (vld) vld_cnt++;
      if (vld && first_vld < 0) first_vld = cyc;
      if (rd) begin
         pops++;
         if (first_rd < 0) first_rd = cyc;
      end
      chk("outstanding", 80'((pops - xfers) <= int'(DEPTH)), 80'(1));

      m_done = 0;
      if (xfer) begin
         chk("xfer_expected", 80'(exp_q.size() != 0), 80'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("xfer_entry", 80'(o), 80'(e));
            frame_accept(e);
         end
         xfers++;
         last_xfer = cyc;
         if (first_xfer < 0) first_xfer = cyc;
      end
      prev_stall = vld && !bus.out_rdy;
      prev_xfer  = xfer;
      prev_out   = o;

      flag_next = q.size();
      popped    = 0;
      pe        = '0;
      if (rd && q.size() != 0) begin
         pe = q.pop_front();
         popped = 1;
         exp_q.push_back(pe);
      end
      if (rst) begin
         q.delete(); exp_q.delete();
         flag_next = 0; popped = 0;
         m_in_frame = 0; m_bytes = 0; m_done = 0; m_err = 0;
         prev_stall = 0; prev_xfer = 0;
         pops = 0; xfers = 0;
      end

      @(posedge clk);
      #1;
      // returning data keeps flowing even across a reset
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
         ret_e[i] = ret_e[i-1];
         ret_v[i] = ret_v[i-1];
      end
      ret_e[0] = pe;
      ret_v[0] = popped;
      flag_cnt = flag_next;
      cyc++;
      drive_inputs();
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (q.size() == 0 && exp_q.size() == 0) break;
      end
      chk("drain_left", 80'(q.size() + exp_q.size()), 80'(0));
      repeat (3) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      ent_t blk[16];
      for (int i = 0; i < int'(RD_LAT); i++) begin
         ret_v[i] = 0;
         ret_e[i] = '0;
      end
      drive_inputs();
      reset_stats();

      // reset
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      chk("rst_out_vld", 80'(s_vld), 80'(0));
      chk("rst_sq_rd", 80'(s_rd), 80'(0));
      chk("rst_out_fields", 80'(s_out), 80'(0));
      chk("rst_frame_bytes", 80'(s_fb), 80'(0));
      chk("rst_err", 80'(s_err), 80'(0));

      // single-beat frame against aempty
      reset_stats();
      mode = 0;
      preload(mk(1, 1, 5));
      drain(50);
      chk("t1_pops", 80'(pops), 80'(1));
      chk("t1_latency", 80'(first_vld - first_rd), 80'(3));
      chk("t1_bytes", 80'(s_fb), 80'(5));
      chk("t1_done_cnt", 80'(done_cnt), 80'(1));

      // 16-entry burst, downstream always ready
      reset_stats();
      for (int i = 0; i < 16; i++) blk[i] = mk(i == 0, i == 15, -1);
      for (int i = 0; i < 16; i++) q.push_back(blk[i]);
      flag_cnt = q.size();
      drive_inputs();
      drain(100);
      chk("t2_pops", 80'(pops), 80'(16));
      chk("t2_xfers", 80'(xfers), 80'(16));
      chk("t2_no_bubble", 80'(last_xfer - first_xfer), 80'(15));
      chk("t2_first_latency", 80'(first_xfer - first_rd), 80'(3));
      chk("t2_done_cnt", 80'(done_cnt), 80'(1));

      // same burst with 1-0-0-1 ready pattern
      reset_stats();
      mode = 1;
      for (int i = 0; i < 16; i++) q.push_back(blk[i]);
      flag_cnt = q.size();
      drive_inputs();
      drain(200);
      chk("t3_pops", 80'(pops), 80'(16));
      chk("t3_xfers", 80'(xfers), 80'(16));
      chk("t3_done_cnt", 80'(done_cnt), 80'(1));

      // three-beat frame 0,0,3
      reset_stats();
      mode = 0;
      q.push_back(mk(1, 0, 0));
      q.push_back(mk(0, 0, 0));
      q.push_back(mk(0, 1, 3));
      flag_cnt = q.size();
      drive_inputs();
      drain(50);
      chk("t4_log_len", 80'(fb_log.size()), 80'(3));
      if (fb_log.size() >= 3) begin
         chk("t4_bytes_0", 80'(fb_log[0]), 80'(8));
         chk("t4_bytes_1", 80'(fb_log[1]), 80'(16));
         chk("t4_bytes_2", 80'(fb_log[2]), 80'(19));
         chk("t4_done_0", 80'(done_log[0]), 80'(0));
         chk("t4_done_1", 80'(done_log[1]), 80'(0));
         chk("t4_done_2", 80'(done_log[2]), 80'(1));
      end

      // 40 full words saturate the narrow counter
      reset_stats();
      mode = 3;
      for (int i = 0; i < 40; i++) q.push_back(mk(i == 0, i == 39, 0));
      flag_cnt = q.size();
      drive_inputs();
      drain(400);
      chk("t5_xfers", 80'(xfers), 80'(40));
      chk("t5_saturated", 80'(s_fb), 80'(SAT));
      chk("t5_done_cnt", 80'(done_cnt), 80'(1));

      // framing violations
      reset_stats();
      mode = 0;
      chk("t6_err_before", 80'(s_err), 80'(0));
      q.push_back(mk(0, 0, 2));
      q.push_back(mk(1, 0, 4));
      q.push_back(mk(0, 0, 1));
      q.push_back(mk(1, 0, 6));
      q.push_back(mk(0, 1, 0));
      flag_cnt = q.size();
      drive_inputs();
      drain(60);
      chk("t6_log_len", 80'(err_log.size()), 80'(5));
      if (err_log.size() >= 5) begin
         chk("t6_err_first", 80'(err_log[0]), 80'(1));
         chk("t6_err_held", 80'(err_log[2]), 80'(1));
         chk("t6_bytes_sot", 80'(fb_log[1]), 80'(4));
         chk("t6_bytes_mid", 80'(fb_log[2]), 80'(5));
         chk("t6_bytes_restart", 80'(fb_log[3]), 80'(6));
         chk("t6_bytes_end", 80'(fb_log[4]), 80'(14));
      end
      chk("t6_err_sticky", 80'(s_err), 80'(1));

      // random framing and random back-pressure
      reset_stats();
      mode = 3;
      for (int i = 0; i < 24; i++) q.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1));
      flag_cnt = q.size();
      drive_inputs();
      drain(400);
      chk("t7_xfers", 80'(xfers), 80'(24));

      // reset with reads in flight and entries in the skid buffer
      reset_stats();
      mode = 2;
      for (int i = 0; i < 8; i++) q.push_back(mk(i == 0, 0, -1));
      flag_cnt = q.size();
      drive_inputs();
      repeat (4) cycle();
      chk("t8_outstanding", 80'(pops - xfers), 80'(4));
      chk("t8_vld_before", 80'(s_vld), 80'(1));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      mode = 0;
      drive_inputs();
      cycle();
      chk("t8_vld_after", 80'(s_vld), 80'(0));
      chk("t8_rd_after", 80'(s_rd), 80'(0));
      chk("t8_bytes_after", 80'(s_fb), 80'(0));
      chk("t8_err_after", 80'(s_err), 80'(0));
      reset_stats();
      repeat (6) cycle();
      chk("t8_late_data", 80'(vld_cnt), 80'(0));

      // recovery after reset
      reset_stats();
      preload(mk(1, 0, 3));
      preload(mk(0, 1, 2));
      drain(50);
      chk("t9_xfers", 80'(xfers), 80'(2));
      chk("t9_bytes", 80'(s_fb), 80'(5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
